// File: rtl/mips_mc_control_fsm.sv
// mips_mc_control_fsm
//   Multi-cycle main controller for the 32-bit MIPS core. It sequences
//   FETCH / DECODE / EXECUTE / MEMORY / WRITEBACK, waits on variable-latency
//   memory and the mul/div unit, and drives CP0 exception entry.
//
// Ports
//   clk, rst             core clock; synchronous active-high reset
//   opcode, funct        IR[31:26], IR[5:0] (stable from DECODE onward)
//   mem_ready            memory completes the current request this cycle
//   branch_taken         branch condition from the datapath
//   overflow             ALU signed overflow (looked at in EXECUTE only)
//   muldiv_done          mul/div result valid
//   divide_zero          divide-by-zero, qualified by muldiv_done
//   ir_write .. reg_write, pc_src, reg_dst, memto_reg,
//   alu_src_a, alu_src_b, alu_control      datapath controls
//   muldiv_start/signed/div                mul/div command
//   cp0_write, exception, cause_sel        exception entry and mtc0
//   instr_retired        one-cycle pulse per completed instruction
//   state_o              current state, for debug
module mips_mc_control_fsm #(
    parameter int ALU_CTRL_W     = 5,
    parameter int MULDIV_TIMEOUT = 64,
    parameter bit EN_MULDIV      = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [5:0]            opcode,
    input  logic [5:0]            funct,
    input  logic                  mem_ready,
    input  logic                  branch_taken,
    input  logic                  overflow,
    input  logic                  muldiv_done,
    input  logic                  divide_zero,
    output logic                  ir_write,
    output logic                  pc_write,
    output logic                  pc_write_cond,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic                  iord,
    output logic                  reg_write,
    output logic [1:0]            pc_src,
    output logic [1:0]            reg_dst,
    output logic [1:0]            memto_reg,
    output logic                  alu_src_a,
    output logic [1:0]            alu_src_b,
    output logic [ALU_CTRL_W-1:0] alu_control,
    output logic                  muldiv_start,
    output logic                  muldiv_signed,
    output logic                  muldiv_div,
    output logic                  cp0_write,
    output logic                  exception,
    output logic [1:0]            cause_sel,
    output logic                  instr_retired,
    output logic [2:0]            state_o
);

    localparam int CNT_W = $clog2(MULDIV_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MULDIV_TIMEOUT - 1);

    localparam logic [ALU_CTRL_W-1:0] ALU_AND  = ALU_CTRL_W'(5'b00000);
    localparam logic [ALU_CTRL_W-1:0] ALU_OR   = ALU_CTRL_W'(5'b00001);
    localparam logic [ALU_CTRL_W-1:0] ALU_ADD  = ALU_CTRL_W'(5'b00010);
    localparam logic [ALU_CTRL_W-1:0] ALU_ADDU = ALU_CTRL_W'(5'b00011);
    localparam logic [ALU_CTRL_W-1:0] ALU_NOR  = ALU_CTRL_W'(5'b00100);
    localparam logic [ALU_CTRL_W-1:0] ALU_SLTU = ALU_CTRL_W'(5'b00101);
    localparam logic [ALU_CTRL_W-1:0] ALU_SUB  = ALU_CTRL_W'(5'b00110);
    localparam logic [ALU_CTRL_W-1:0] ALU_SLT  = ALU_CTRL_W'(5'b00111);
    localparam logic [ALU_CTRL_W-1:0] ALU_XOR  = ALU_CTRL_W'(5'b01011);
    localparam logic [ALU_CTRL_W-1:0] ALU_SUBU = ALU_CTRL_W'(5'b01111);
    localparam logic [ALU_CTRL_W-1:0] ALU_LUI  = ALU_CTRL_W'(5'b11111);

    localparam logic [1:0] CAUSE_OVF = 2'b00;
    localparam logic [1:0] CAUSE_ILL = 2'b01;
    localparam logic [1:0] CAUSE_DZ  = 2'b10;
    localparam logic [1:0] CAUSE_TMO = 2'b11;

    typedef enum logic [2:0] {
        S_FETCH       = 3'd0,
        S_DECODE      = 3'd1,
        S_EXECUTE     = 3'd2,
        S_MEMORY      = 3'd3,
        S_WRITEBACK   = 3'd4,
        S_MULDIV_WAIT = 3'd5,
        S_EXCEPT      = 3'd6
    } state_t;

    // C_ALU_R is the all-zero encoding, so a cleared class register reads ALU-R.
    typedef enum logic [3:0] {
        C_ALU_R, C_ALU_I, C_LOAD, C_STORE, C_BRANCH, C_JUMP,
        C_JR, C_MULDIV, C_HILO, C_CP0, C_ILLEGAL
    } cls_t;

    state_t                  state_q, state_nx;
    cls_t                    cls_q, dec_cls;
    logic [ALU_CTRL_W-1:0]   alu_q, dec_alu;
    logic                    trap_q, dec_trap;   // signed op that traps on overflow
    logic [1:0]              fn_q;               // funct[1:0]: mul/div and hi/lo variant
    logic                    jal_q;
    logic                    mtc0_q;
    logic [1:0]              cause_q, cause_nx;
    logic                    cause_ld;
    logic [CNT_W-1:0]        cnt_q;

    // Instruction classification, consumed in DECODE.
    always_comb begin
        dec_cls  = C_ILLEGAL;
        dec_alu  = ALU_ADD;
        dec_trap = 1'b0;
        case (opcode)
            6'b000000: begin
                case (funct)
                    6'b100000: begin dec_cls = C_ALU_R; dec_alu = ALU_ADD; dec_trap = 1'b1; end
                    6'b100001: begin dec_cls = C_ALU_R; dec_alu = ALU_ADDU; end
                    6'b100010: begin dec_cls = C_ALU_R; dec_alu = ALU_SUB; dec_trap = 1'b1; end
                    6'b100011: begin dec_cls = C_ALU_R; dec_alu = ALU_SUBU; end
                    6'b100100: begin dec_cls = C_ALU_R; dec_alu = ALU_AND; end
                    6'b100101: begin dec_cls = C_ALU_R; dec_alu = ALU_OR; end
                    6'b100110: begin dec_cls = C_ALU_R; dec_alu = ALU_XOR; end
                    6'b100111: begin dec_cls = C_ALU_R; dec_alu = ALU_NOR; end
                    6'b101010: begin dec_cls = C_ALU_R; dec_alu = ALU_SLT; end
                    6'b101011: begin dec_cls = C_ALU_R; dec_alu = ALU_SLTU; end
                    6'b001000: dec_cls = C_JR;
                    6'b011000, 6'b011001, 6'b011010, 6'b011011:
                        if (EN_MULDIV) dec_cls = C_MULDIV;
                    6'b010000, 6'b010001, 6'b010010, 6'b010011:
                        if (EN_MULDIV) dec_cls = C_HILO;
                    default: ;
                endcase
            end
            6'b001000: begin dec_cls = C_ALU_I; dec_alu = ALU_ADD; dec_trap = 1'b1; end
            6'b001001: begin dec_cls = C_ALU_I; dec_alu = ALU_ADDU; end
            6'b001010: begin dec_cls = C_ALU_I; dec_alu = ALU_SLT; end
            6'b001011: begin dec_cls = C_ALU_I; dec_alu = ALU_SLTU; end
            6'b001100: begin dec_cls = C_ALU_I; dec_alu = ALU_AND; end
            6'b001101: begin dec_cls = C_ALU_I; dec_alu = ALU_OR; end
            6'b001110: begin dec_cls = C_ALU_I; dec_alu = ALU_XOR; end
            6'b001111: begin dec_cls = C_ALU_I; dec_alu = ALU_LUI; end
            6'b000010, 6'b000011: dec_cls = C_JUMP;
            6'b000100, 6'b000101, 6'b000110, 6'b000111: dec_cls = C_BRANCH;
            6'b100000, 6'b100001, 6'b100011, 6'b100100, 6'b100101: dec_cls = C_LOAD;
            6'b101000, 6'b101001, 6'b101011: dec_cls = C_STORE;
            6'b010000: dec_cls = C_CP0;
            default: ;
        endcase
    end

    // State, class, cause and wait-counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_FETCH;
            cls_q   <= C_ALU_R;
            alu_q   <= '0;
            trap_q  <= 1'b0;
            fn_q    <= 2'b00;
            jal_q   <= 1'b0;
            mtc0_q  <= 1'b0;
            cause_q <= 2'b00;
            cnt_q   <= '0;
        end else begin
            state_q <= state_nx;
            if (state_q == S_DECODE) begin
                cls_q  <= dec_cls;
                alu_q  <= dec_alu;
                trap_q <= dec_trap;
                fn_q   <= funct[1:0];
                jal_q  <= opcode[0];
                mtc0_q <= (funct != 6'd0);
            end
            if (cause_ld) cause_q <= cause_nx;
            // Zero outside the wait state so every entry starts at 0; saturates.
            if (state_q != S_MULDIV_WAIT) cnt_q <= '0;
            else if (cnt_q != CNT_LAST)   cnt_q <= cnt_q + 1'b1;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nx = state_q;
        cause_ld = 1'b0;
        cause_nx = cause_q;
        case (state_q)
            S_FETCH: if (mem_ready) state_nx = S_DECODE;
            S_DECODE: begin
                if (dec_cls == C_ILLEGAL) begin
                    state_nx = S_EXCEPT;
                    cause_ld = 1'b1;
                    cause_nx = CAUSE_ILL;
                end else begin
                    state_nx = S_EXECUTE;
                end
            end
            S_EXECUTE: begin
                case (cls_q)
                    C_ALU_R, C_ALU_I: begin
                        if (trap_q && overflow) begin
                            state_nx = S_EXCEPT;
                            cause_ld = 1'b1;
                            cause_nx = CAUSE_OVF;
                        end else begin
                            state_nx = S_WRITEBACK;
                        end
                    end
                    C_LOAD, C_STORE: state_nx = S_MEMORY;
                    C_MULDIV:        state_nx = S_MULDIV_WAIT;
                    C_HILO:          state_nx = fn_q[0] ? S_FETCH : S_WRITEBACK;
                    C_CP0:           state_nx = mtc0_q ? S_FETCH : S_WRITEBACK;
                    default:         state_nx = S_FETCH;
                endcase
            end
            S_MEMORY: if (mem_ready) state_nx = (cls_q == C_STORE) ? S_FETCH : S_WRITEBACK;
            S_WRITEBACK: state_nx = S_FETCH;
            S_MULDIV_WAIT: begin
                // A completion in the same cycle as the timeout wins.
                if (muldiv_done) begin
                    if (divide_zero) begin
                        state_nx = S_EXCEPT;
                        cause_ld = 1'b1;
                        cause_nx = CAUSE_DZ;
                    end else begin
                        state_nx = S_FETCH;
                    end
                end else if (cnt_q == CNT_LAST) begin
                    state_nx = S_EXCEPT;
                    cause_ld = 1'b1;
                    cause_nx = CAUSE_TMO;
                end
            end
            S_EXCEPT: state_nx = S_FETCH;
            default:  state_nx = S_FETCH;
        endcase
    end

    // Output decode. Everything is held at zero while rst is high so an
    // in-flight memory request is dropped in the reset cycle itself.
    always_comb begin
        ir_write      = 1'b0;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        mem_req       = 1'b0;
        mem_we        = 1'b0;
        iord          = 1'b0;
        reg_write     = 1'b0;
        pc_src        = 2'b00;
        reg_dst       = 2'b00;
        memto_reg     = 2'b00;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        alu_control   = '0;
        muldiv_start  = 1'b0;
        muldiv_signed = 1'b0;
        muldiv_div    = 1'b0;
        cp0_write     = 1'b0;
        exception     = 1'b0;
        cause_sel     = 2'b00;
        instr_retired = 1'b0;
        state_o       = 3'd0;
        if (!rst) begin
            state_o = state_q;
            case (state_q)
                S_FETCH: begin
                    mem_req     = 1'b1;
                    alu_src_b   = 2'b01;
                    alu_control = ALU_ADD;
                    ir_write    = mem_ready;
                    pc_write    = mem_ready;
                end
                S_DECODE: begin
                    alu_src_b   = 2'b11;
                    alu_control = ALU_ADD;
                end
                S_EXECUTE: begin
                    alu_src_a = 1'b1;
                    case (cls_q)
                        C_ALU_R: alu_control = alu_q;
                        C_ALU_I: begin
                            alu_src_b   = 2'b10;
                            alu_control = alu_q;
                        end
                        C_LOAD, C_STORE: begin
                            alu_src_b   = 2'b10;
                            alu_control = ALU_ADD;
                        end
                        C_BRANCH: begin
                            // pc_write mirrors the taken condition so a datapath
                            // using pc_write | (pc_write_cond & cond) sees one answer.
                            alu_control   = ALU_SUB;
                            pc_write_cond = 1'b1;
                            pc_write      = branch_taken;
                            pc_src        = 2'b01;
                            instr_retired = 1'b1;
                        end
                        C_JUMP: begin
                            pc_write      = 1'b1;
                            pc_src        = 2'b10;
                            reg_write     = jal_q;
                            reg_dst       = jal_q ? 2'b10 : 2'b00;
                            instr_retired = 1'b1;
                        end
                        C_JR: begin
                            // rs | rt, with rt = $0 for jr, passes rs through.
                            alu_control   = ALU_OR;
                            pc_write      = 1'b1;
                            instr_retired = 1'b1;
                        end
                        C_MULDIV: begin
                            muldiv_start  = 1'b1;
                            muldiv_signed = ~fn_q[0];
                            muldiv_div    = fn_q[1];
                        end
                        C_HILO: instr_retired = fn_q[0];
                        C_CP0: begin
                            cp0_write     = mtc0_q;
                            instr_retired = mtc0_q;
                        end
                        default: ;
                    endcase
                end
                S_MEMORY: begin
                    mem_req       = 1'b1;
                    iord          = 1'b1;
                    mem_we        = (cls_q == C_STORE);
                    instr_retired = mem_ready && (cls_q == C_STORE);
                end
                S_WRITEBACK: begin
                    reg_write     = 1'b1;
                    instr_retired = 1'b1;
                    case (cls_q)
                        C_ALU_R: reg_dst = 2'b01;
                        C_LOAD:  memto_reg = 2'b01;
                        C_HILO: begin
                            reg_dst   = 2'b01;
                            memto_reg = {1'b1, fn_q[1]};
                        end
                        default: ;
                    endcase
                end
                S_MULDIV_WAIT: instr_retired = muldiv_done && !divide_zero;
                S_EXCEPT: begin
                    exception = 1'b1;
                    cp0_write = 1'b1;
                    pc_write  = 1'b1;
                    pc_src    = 2'b11;
                    cause_sel = cause_q;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mips_mc_control_fsm.sv
// Bench for mips_mc_control_fsm. Three instances share one input stream:
// [0] defaults, [1] MULDIV_TIMEOUT=4, [2] EN_MULDIV=0. Each vector is one
// clock cycle: inputs driven just after the rising edge, every output of the
// selected instance compared on the falling edge.
module tb_mips_mc_control_fsm;

    typedef struct packed {
        logic       ir_write;
        logic       pc_write;
        logic       pc_write_cond;
        logic       mem_req;
        logic       mem_we;
        logic       iord;
        logic       reg_write;
        logic [1:0] pc_src;
        logic [1:0] reg_dst;
        logic [1:0] memto_reg;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [4:0] alu_control;
        logic       muldiv_start;
        logic       muldiv_signed;
        logic       muldiv_div;
        logic       cp0_write;
        logic       exception;
        logic [1:0] cause_sel;
        logic       instr_retired;
        logic [2:0] state_o;
    } obs_t;

    typedef struct {
        string      tag;
        int         dut;
        logic       rst;
        logic [5:0] op;
        logic [5:0] fn;
        logic       mr, bt, ovf, md, dz;
        obs_t       want;
    } vec_t;

    localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011;
    localparam logic [5:0] OP_J = 6'b000010, OP_JAL = 6'b000011, OP_BEQ = 6'b000100;
    localparam logic [5:0] OP_ADDIU = 6'b001001, OP_BAD = 6'b111111;
    localparam logic [5:0] FN_ADD = 6'b100000, FN_MULT = 6'b011000, FN_MULTU = 6'b011001;
    localparam logic [5:0] FN_DIV = 6'b011010, FN_MFLO = 6'b010010;
    localparam logic [4:0] A_ADD = 5'b00010, A_ADDU = 5'b00011, A_SUB = 5'b00110;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] opcode, funct;
    logic       mem_ready, branch_taken, overflow, muldiv_done, divide_zero;
    wire [31:0] ov [3];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        mips_mc_control_fsm #(
            .ALU_CTRL_W    (5),
            .MULDIV_TIMEOUT((g == 1) ? 4 : 64),
            .EN_MULDIV     (g != 2)
        ) u_dut (
            .clk          (clk),
            .rst          (rst),
            .opcode       (opcode),
            .funct        (funct),
            .mem_ready    (mem_ready),
            .branch_taken (branch_taken),
            .overflow     (overflow),
            .muldiv_done  (muldiv_done),
            .divide_zero  (divide_zero),
            .ir_write     (ov[g][31]),
            .pc_write     (ov[g][30]),
            .pc_write_cond(ov[g][29]),
            .mem_req      (ov[g][28]),
            .mem_we       (ov[g][27]),
            .iord         (ov[g][26]),
            .reg_write    (ov[g][25]),
            .pc_src       (ov[g][24:23]),
            .reg_dst      (ov[g][22:21]),
            .memto_reg    (ov[g][20:19]),
            .alu_src_a    (ov[g][18]),
            .alu_src_b    (ov[g][17:16]),
            .alu_control  (ov[g][15:11]),
            .muldiv_start (ov[g][10]),
            .muldiv_signed(ov[g][9]),
            .muldiv_div   (ov[g][8]),
            .cp0_write    (ov[g][7]),
            .exception    (ov[g][6]),
            .cause_sel    (ov[g][5:4]),
            .instr_retired(ov[g][3]),
            .state_o      (ov[g][2:0])
        );
    end

    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    vec_t tbl[$];

    // Hand-written expected output patterns per state.
    function automatic obs_t o_zero();
        obs_t e = '0;
        return e;
    endfunction

    function automatic obs_t o_fetch(input logic rdy);
        obs_t e = '0;
        e.mem_req = 1'b1; e.alu_src_b = 2'b01; e.alu_control = A_ADD;
        e.ir_write = rdy; e.pc_write = rdy;
        return e;
    endfunction

    function automatic obs_t o_dec();
        obs_t e = '0;
        e.state_o = 3'd1; e.alu_src_b = 2'b11; e.alu_control = A_ADD;
        return e;
    endfunction

    function automatic obs_t o_exec(input logic [1:0] srcb, input logic [4:0] alu);
        obs_t e = '0;
        e.state_o = 3'd2; e.alu_src_a = 1'b1; e.alu_src_b = srcb; e.alu_control = alu;
        return e;
    endfunction

    function automatic obs_t o_mem(input logic we, input logic ret);
        obs_t e = '0;
        e.state_o = 3'd3; e.mem_req = 1'b1; e.iord = 1'b1; e.mem_we = we; e.instr_retired = ret;
        return e;
    endfunction

    function automatic obs_t o_wb(input logic [1:0] dst, input logic [1:0] mtr);
        obs_t e = '0;
        e.state_o = 3'd4; e.reg_write = 1'b1; e.reg_dst = dst; e.memto_reg = mtr;
        e.instr_retired = 1'b1;
        return e;
    endfunction

    function automatic obs_t o_wait(input logic ret);
        obs_t e = '0;
        e.state_o = 3'd5; e.instr_retired = ret;
        return e;
    endfunction

    function automatic obs_t o_exc(input logic [1:0] cause);
        obs_t e = '0;
        e.state_o = 3'd6; e.exception = 1'b1; e.cp0_write = 1'b1; e.pc_write = 1'b1;
        e.pc_src = 2'b11; e.cause_sel = cause;
        return e;
    endfunction

    function automatic obs_t o_md(input logic sgn, input logic dv);
        obs_t e = o_exec(2'b00, 5'b00000);
        e.muldiv_start = 1'b1; e.muldiv_signed = sgn; e.muldiv_div = dv;
        return e;
    endfunction

    function automatic vec_t mk(input string tag, input int dut, input logic r,
                                input logic [5:0] op, input logic [5:0] fn,
                                input logic mr, input logic bt, input logic ovf,
                                input logic md, input logic dz, input obs_t want);
        vec_t v;
        v.tag = tag; v.dut = dut; v.rst = r; v.op = op; v.fn = fn;
        v.mr = mr; v.bt = bt; v.ovf = ovf; v.md = md; v.dz = dz; v.want = want;
        return v;
    endfunction

    task automatic step(input vec_t v);
        obs_t act;
        rst = v.rst; opcode = v.op; funct = v.fn; mem_ready = v.mr;
        branch_taken = v.bt; overflow = v.ovf; muldiv_done = v.md; divide_zero = v.dz;
        @(negedge clk);
        act = ov[v.dut];
        total++;
        if (act !== v.want) begin
            bad++;
            $display("FAIL %s cycle %0d dut%0d: got state=%0d outs=%h, need state=%0d outs=%h",
                     v.tag, cyc, v.dut, act.state_o, act, v.want.state_o, v.want);
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    initial begin
        obs_t e;
        rst = 1'b1; opcode = '0; funct = '0; mem_ready = 1'b0; branch_taken = 1'b0;
        overflow = 1'b0; muldiv_done = 1'b0; divide_zero = 1'b0;
        @(posedge clk);
        #1;

        // ---------------- main table (instance 0) ----------------
        tbl.push_back(mk("reset", 0, 1, OP_R, FN_ADD, 1, 0, 0, 0, 0, o_zero()));
        // add, zero-wait: 0 -> 1 -> 2 -> 4 -> 0
        tbl.push_back(mk("add_f",  0, 0, OP_R, FN_ADD, 1, 0, 0, 0, 0, o_fetch(1)));
        tbl.push_back(mk("add_d",  0, 0, OP_R, FN_ADD, 0, 0, 0, 0, 0, o_dec()));
        tbl.push_back(mk("add_x",  0, 0, OP_R, FN_ADD, 0, 0, 0, 0, 0, o_exec(2'b00, A_ADD)));
        tbl.push_back(mk("add_wb", 0, 0, OP_R, FN_ADD, 0, 0, 0, 0, 0, o_wb(2'b01, 2'b00)));
        // lw, 3 wait cycles in FETCH and in MEMORY: 11 cycles
        for (int i = 0; i < 3; i++)
            tbl.push_back(mk("lw_fw", 0, 0, OP_LW, 6'd0, 0, 0, 0, 0, 0, o_fetch(0)));
        tbl.push_back(mk("lw_f",  0, 0, OP_LW, 6'd0, 1, 0, 0, 0, 0, o_fetch(1)));
        tbl.push_back(mk("lw_d",  0, 0, OP_LW, 6'd0, 0, 0, 0, 0, 0, o_dec()));
        tbl.push_back(mk("lw_x",  0, 0, OP_LW, 6'd0, 0, 0, 0, 0, 0, o_exec(2'b10, A_ADD)));
        for (int i = 0; i < 3; i++)
            tbl.push_back(mk("lw_mw", 0, 0, OP_LW, 6'd0, 0, 0, 0, 0, 0, o_mem(0, 0)));
        tbl.push_back(mk("lw_m",  0, 0, OP_LW, 6'd0, 1, 0, 0, 0, 0, o_mem(0, 0)));
        tbl.push_back(mk("lw_wb", 0, 0, OP_LW, 6'd0, 0, 0, 0, 0, 0, o_wb(2'b00, 2'b01)));
        // sw, zero-wait: 4 cycles, retires in MEMORY
        tbl.push_back(mk("sw_f", 0, 0, OP_SW, 6'd0, 1, 0, 0, 0, 0, o_fetch(1)));
        tbl.push_back(mk("sw_d", 0, 0, OP_SW, 6'd0, 0, 0, 0, 0, 0, o_dec()));
        tbl.push_back(mk("sw_x", 0, 0, OP_SW, 6'd0, 0, 0, 0, 0, 0, o_exec(2'b10, A_ADD)));
        tbl.push_back(mk("sw_m", 0, 0, OP_SW, 6'd0, 1, 0, 0, 0, 0, o_mem(1, 1)));
        // j, jal: 3 cycles
        e = o_exec(2'b00, 5'b00000); e.pc_write = 1'b1; e.pc_src = 2'b10; e.instr_retired = 1'b1;
        tbl.push_back(mk("j_f", 0, 0, OP_J, 6'd0, 1, 0, 0, 0, 0, o_fetch(1)));
        tbl.push_back(mk("j_d", 0, 0, OP_J, 6'd0, 0, 0, 0, 0, 0, o_dec()));
        tbl.push_back(mk("j_x", 0, 0, OP_J, 6'd0, 0, 0, 0, 0, 0, e));
        e.reg_write = 1'b1; e.reg_dst = 2'b10;
        tbl.push_back(mk("jal_f", 0, 0, OP_JAL, 6'd0, 1, 0, 0, 0, 0, o_fetch(1)));
        tbl.push_back(mk("jal_d", 0, 0, OP_JAL, 6'd0, 0, 0, 0, 0, 0, o_dec()));
        tbl.push_back(mk("jal_x", 0, 0, OP_JAL, 6'd0, 0, 0, 0, 0, 0, e));
        // beq not taken / taken
        e = o_exec(2'b00, A_SUB); e.pc_write_cond = 1'b1; e.pc_src = 2'b01; e.instr_retired = 1'b1;
        tbl.push_back(mk("beqn_f", 0, 0, OP_BEQ, 6'd0, 1, 0, 0, 0, 0, o_fetch(1)));
        tbl.push_back(mk("beqn_d", 0, 0, OP_BEQ, 6'd0, 0, 0, 0, 0, 0, o_dec()));
        tbl.push_back(mk("beqn_x", 0, 0, OP_BEQ, 6'd0, 0, 0, 0, 0, 0, e));
        e.pc_write = 1'b1;
        tbl.push_back(mk("beqt_f", 0, 0, OP_BEQ, 6'd0, 1, 1, 0, 0, 0, o_fetch(1)));
        tbl.push_back(mk("beqt_d", 0, 0, OP_BEQ, 6'd0, 0, 1, 0, 0, 0, o_dec()));
        tbl.push_back(mk("beqt_x", 0, 0, OP_BEQ, 6'd0, 0, 1, 0, 0, 0, e));
        // addiu ignores overflow
        tbl.push_back(mk("addiu_f",  0, 0, OP_ADDIU, 6'd0, 1, 0, 1, 0, 0, o_fetch(1)));
        tbl.push_back(mk("addiu_d",  0, 0, OP_ADDIU, 6'd0, 0, 0, 1, 0, 0, o_dec()));
        tbl.push_back(mk("addiu_x",  0, 0, OP_ADDIU, 6'd0, 0, 0, 1, 0, 0, o_exec(2'b10, A_ADDU)));
        tbl.push_back(mk("addiu_wb", 0, 0, OP_ADDIU, 6'd0, 0, 0, 1, 0, 0, o_wb(2'b00, 2'b00)));
        // mflo writes LO into rd
        tbl.push_back(mk("mflo_f",  0, 0, OP_R, FN_MFLO, 1, 0, 0, 0, 0, o_fetch(1)));
        tbl.push_back(mk("mflo_d",  0, 0, OP_R, FN_MFLO, 0, 0, 0, 0, 0, o_dec()));
        tbl.push_back(mk("mflo_x",  0, 0, OP_R, FN_MFLO, 0, 0, 0, 0, 0, o_exec(2'b00, 5'b00000)));
        tbl.push_back(mk("mflo_wb", 0, 0, OP_R, FN_MFLO, 0, 0, 0, 0, 0, o_wb(2'b01, 2'b11)));
        // add with overflow: exception, cause 00, no write, no retire
        tbl.push_back(mk("ovf_f",  0, 0, OP_R, FN_ADD, 1, 0, 1, 0, 0, o_fetch(1)));
        tbl.push_back(mk("ovf_d",  0, 0, OP_R, FN_ADD, 0, 0, 1, 0, 0, o_dec()));
        tbl.push_back(mk("ovf_x",  0, 0, OP_R, FN_ADD, 0, 0, 1, 0, 0, o_exec(2'b00, A_ADD)));
        tbl.push_back(mk("ovf_ex", 0, 0, OP_R, FN_ADD, 0, 0, 1, 0, 0, o_exc(2'b00)));
        tbl.push_back(mk("ovf_fw", 0, 0, OP_BAD, 6'd0, 0, 0, 0, 0, 0, o_fetch(0)));
        // illegal opcode: cause 01
        tbl.push_back(mk("ill_f",  0, 0, OP_BAD, 6'd0, 1, 0, 0, 0, 0, o_fetch(1)));
        tbl.push_back(mk("ill_d",  0, 0, OP_BAD, 6'd0, 0, 0, 0, 0, 0, o_dec()));
        tbl.push_back(mk("ill_ex", 0, 0, OP_BAD, 6'd0, 0, 0, 0, 0, 0, o_exc(2'b01)));
        tbl.push_back(mk("ill_fw", 0, 0, OP_BAD, 6'd0, 0, 0, 0, 0, 0, o_fetch(0)));

        foreach (tbl[i]) step(tbl[i]);

        // ---------------- multi-cycle corner cases ----------------
        // div, done after 5 wait cycles with divide_zero: cause 10
        step(mk("dz_rst", 0, 1, OP_R, FN_DIV, 0, 0, 0, 0, 0, o_zero()));
        step(mk("dz_f",   0, 0, OP_R, FN_DIV, 1, 0, 0, 0, 0, o_fetch(1)));
        step(mk("dz_d",   0, 0, OP_R, FN_DIV, 0, 0, 0, 0, 0, o_dec()));
        step(mk("dz_x",   0, 0, OP_R, FN_DIV, 0, 0, 0, 0, 0, o_md(1, 1)));
        for (int i = 0; i < 4; i++)
            step(mk("dz_w", 0, 0, OP_R, FN_DIV, 0, 0, 0, 0, 0, o_wait(0)));
        step(mk("dz_w5",  0, 0, OP_R, FN_DIV, 0, 0, 0, 1, 1, o_wait(0)));
        step(mk("dz_ex",  0, 0, OP_R, FN_DIV, 0, 0, 0, 0, 0, o_exc(2'b10)));
        step(mk("dz_fw",  0, 0, OP_R, FN_DIV, 0, 0, 0, 0, 0, o_fetch(0)));

        // multu completing normally retires from the wait state
        step(mk("mu_rst", 0, 1, OP_R, FN_MULTU, 0, 0, 0, 0, 0, o_zero()));
        step(mk("mu_f",   0, 0, OP_R, FN_MULTU, 1, 0, 0, 0, 0, o_fetch(1)));
        step(mk("mu_d",   0, 0, OP_R, FN_MULTU, 0, 0, 0, 0, 0, o_dec()));
        step(mk("mu_x",   0, 0, OP_R, FN_MULTU, 0, 0, 0, 0, 0, o_md(0, 0)));
        step(mk("mu_w",   0, 0, OP_R, FN_MULTU, 0, 0, 0, 1, 0, o_wait(1)));
        step(mk("mu_fw",  0, 0, OP_R, FN_MULTU, 0, 0, 0, 0, 0, o_fetch(0)));

        // MULDIV_TIMEOUT=4, no done: exception 11 after 4 wait cycles
        step(mk("to_rst", 1, 1, OP_R, FN_DIV, 0, 0, 0, 0, 0, o_zero()));
        step(mk("to_f",   1, 0, OP_R, FN_DIV, 1, 0, 0, 0, 0, o_fetch(1)));
        step(mk("to_d",   1, 0, OP_R, FN_DIV, 0, 0, 0, 0, 0, o_dec()));
        step(mk("to_x",   1, 0, OP_R, FN_DIV, 0, 0, 0, 0, 0, o_md(1, 1)));
        for (int i = 0; i < 4; i++)
            step(mk("to_w", 1, 0, OP_R, FN_DIV, 0, 0, 0, 0, 0, o_wait(0)));
        step(mk("to_ex",  1, 0, OP_R, FN_DIV, 0, 0, 0, 0, 0, o_exc(2'b11)));
        step(mk("to_fw",  1, 0, OP_R, FN_DIV, 0, 0, 0, 0, 0, o_fetch(0)));

        // done in the timeout cycle wins over the timeout
        step(mk("pr_rst", 1, 1, OP_R, FN_DIV, 0, 0, 0, 0, 0, o_zero()));
        step(mk("pr_f",   1, 0, OP_R, FN_DIV, 1, 0, 0, 0, 0, o_fetch(1)));
        step(mk("pr_d",   1, 0, OP_R, FN_DIV, 0, 0, 0, 0, 0, o_dec()));
        step(mk("pr_x",   1, 0, OP_R, FN_DIV, 0, 0, 0, 0, 0, o_md(1, 1)));
        for (int i = 0; i < 3; i++)
            step(mk("pr_w", 1, 0, OP_R, FN_DIV, 0, 0, 0, 0, 0, o_wait(0)));
        step(mk("pr_w4",  1, 0, OP_R, FN_DIV, 0, 0, 0, 1, 0, o_wait(1)));
        step(mk("pr_fw",  1, 0, OP_R, FN_DIV, 0, 0, 0, 0, 0, o_fetch(0)));

        // EN_MULDIV=0: mult is illegal
        step(mk("nm_rst", 2, 1, OP_R, FN_MULT, 0, 0, 0, 0, 0, o_zero()));
        step(mk("nm_f",   2, 0, OP_R, FN_MULT, 1, 0, 0, 0, 0, o_fetch(1)));
        step(mk("nm_d",   2, 0, OP_R, FN_MULT, 0, 0, 0, 0, 0, o_dec()));
        step(mk("nm_ex",  2, 0, OP_R, FN_MULT, 0, 0, 0, 0, 0, o_exc(2'b01)));
        step(mk("nm_fw",  2, 0, OP_R, FN_MULT, 0, 0, 0, 0, 0, o_fetch(0)));

        // reset while a store waits in MEMORY: request drops in the same cycle
        step(mk("rm_rst", 0, 1, OP_SW, 6'd0, 0, 0, 0, 0, 0, o_zero()));
        step(mk("rm_f",   0, 0, OP_SW, 6'd0, 1, 0, 0, 0, 0, o_fetch(1)));
        step(mk("rm_d",   0, 0, OP_SW, 6'd0, 0, 0, 0, 0, 0, o_dec()));
        step(mk("rm_x",   0, 0, OP_SW, 6'd0, 0, 0, 0, 0, 0, o_exec(2'b10, A_ADD)));
        step(mk("rm_mw",  0, 0, OP_SW, 6'd0, 0, 0, 0, 0, 0, o_mem(1, 0)));
        step(mk("rm_hit", 0, 1, OP_SW, 6'd0, 0, 0, 0, 0, 0, o_zero()));
        step(mk("rm_fw",  0, 0, OP_SW, 6'd0, 0, 0, 0, 0, 0, o_fetch(0)));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
